cache_ctrl: RTL and testbench

//   Per-request sequencer between the CPU port and the set array plus backing memory. Decodes the

---
 rtl/cache_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: per-request sequencer between the CPU port, the set array and backing memory.
// A request is accepted only in IDLE. The controller compares the address against the
// selected set. On a miss it writes back a dirty line word by word, fills the line from
// memory in four words, and then replays the original access once.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   cpu_*_i / cpu_*_o    request strobe/we/addr{tag,index,word}/wdata in; rdata, ready, err, busy out
//   set_*_o              command to the selected set (enable/comp/write, word, tag, data, valid)
//   set_*_i              response from the selected set (hit, dirty, valid, tag, data, ack)
//   mem_*_o / mem_*_i    word-wide memory request (req/we/addr/wdata) and response (rdata/ack)
//
// state    | meaning
// IDLE     | waiting for cpu_req
// CMP      | compare access to the set (also used for the replay)
// REL      | set_enable low for one cycle between two set commands
// WB_RD    | read word w of the victim line from the set
// WB_MEM   | write that word to memory
// FILL_MEM | read word w of the new line from memory
// FILL_WR  | write that word into the set
// DONE     | cpu_ready pulse
// ERR      | cpu_ready + cpu_err pulse
module cache_ctrl #(
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [6+IDX_W:0]  cpu_addr_i,
  input  logic [15:0]       cpu_wdata_i,
  output logic [15:0]       cpu_rdata_o,
  output logic              cpu_ready_o,
  output logic              cpu_err_o,
  output logic              cpu_busy_o,
  output logic [IDX_W-1:0]  set_sel_o,
  output logic              set_enable_o,
  output logic              set_comp_o,
  output logic              set_write_o,
  output logic [1:0]        set_word_o,
  output logic [4:0]        set_tag_o,
  output logic [15:0]       set_data_o,
  output logic              set_valid_o,
  input  logic              set_hit_i,
  input  logic              set_dirty_i,
  input  logic              set_valid_out_i,
  input  logic              set_ack_i,
  input  logic [4:0]        set_tag_out_i,
  input  logic [15:0]       set_data_out_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [6+IDX_W:0]  mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  input  logic [15:0]       mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    IDLE, CMP, REL, WB_RD, WB_MEM, FILL_MEM, FILL_WR, DONE, ERR
  } state_t;

  state_t            state_q, state_d, ret_q, ret_d;
  logic              we_q, we_d, replay_q, replay_d;
  logic [6+IDX_W:0]  addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0]       wb_data_q, wb_data_d, fill_q, fill_d;
  logic [4:0]        wb_tag_q, wb_tag_d;
  logic [1:0]        w_q, w_d;
  logic [TW-1:0]     tmr_q, tmr_d;

  logic [4:0]        tag;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        word;

  assign tag  = addr_q[6+IDX_W -: 5];
  assign idx  = addr_q[IDX_W+1:2];
  assign word = addr_q[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      we_q      <= 1'b0;
      replay_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wb_data_q <= '0;
      fill_q    <= '0;
      wb_tag_q  <= '0;
      w_q       <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      we_q      <= we_d;
      replay_q  <= replay_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wb_data_q <= wb_data_d;
      fill_q    <= fill_d;
      wb_tag_q  <= wb_tag_d;
      w_q       <= w_d;
      tmr_q     <= tmr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    we_d      = we_q;
    replay_d  = replay_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wb_data_d = wb_data_q;
    fill_d    = fill_q;
    wb_tag_d  = wb_tag_q;
    w_d       = w_q;
    tmr_d     = tmr_q;

    cpu_rdata_o  = '0;
    cpu_ready_o  = 1'b0;
    cpu_err_o    = 1'b0;
    cpu_busy_o   = (state_q != IDLE);
    set_sel_o    = '0;
    set_enable_o = 1'b0;
    set_comp_o   = 1'b0;
    set_write_o  = 1'b0;
    set_word_o   = '0;
    set_tag_o    = '0;
    set_data_o   = '0;
    set_valid_o  = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;

    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          we_d     = cpu_we_i;
          addr_d   = cpu_addr_i;
          wdata_d  = cpu_wdata_i;
          w_d      = '0;
          replay_d = 1'b0;
          state_d  = CMP;
        end
      end
      CMP: begin
        set_sel_o    = idx;
        set_enable_o = 1'b1;
        set_comp_o   = 1'b1;
        set_write_o  = we_q;
        set_word_o   = word;
        set_tag_o    = tag;
        set_data_o   = wdata_q;
        set_valid_o  = we_q;
        if (set_ack_i) begin
          w_d = '0;
          if (set_hit_i && set_valid_out_i) begin
            rdata_d = set_data_out_i;
            state_d = DONE;
          end else if (replay_q) begin
            // the line was just filled; missing again means the set is misbehaving
            state_d = ERR;
          end else if (set_valid_out_i && set_dirty_i) begin
            ret_d   = WB_RD;
            state_d = REL;
          end else begin
            state_d = FILL_MEM;
          end
        end else if (tmr_q == '0) begin
          state_d = ERR;
        end
      end
      REL: state_d = ret_q;
      WB_RD: begin
        set_sel_o    = idx;
        set_enable_o = 1'b1;
        set_word_o   = w_q;
        if (set_ack_i) begin
          wb_data_d = set_data_out_i;
          wb_tag_d  = set_tag_out_i;
          state_d   = WB_MEM;
        end else if (tmr_q == '0) begin
          state_d = ERR;
        end
      end
      WB_MEM: begin
        // set_enable stays low here, which provides the gap before the next WB_RD
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {wb_tag_q, idx, w_q};
        mem_wdata_o = wb_data_q;
        if (mem_ack_i) begin
          w_d     = w_q + 2'd1;
          state_d = (w_q == 2'd3) ? FILL_MEM : WB_RD;
        end else if (tmr_q == '0) begin
          state_d = ERR;
        end
      end
      FILL_MEM: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {tag, idx, w_q};
        if (mem_ack_i) begin
          fill_d  = mem_rdata_i;
          state_d = FILL_WR;
        end else if (tmr_q == '0) begin
          state_d = ERR;
        end
      end
      FILL_WR: begin
        set_sel_o    = idx;
        set_enable_o = 1'b1;
        set_write_o  = 1'b1;
        set_word_o   = w_q;
        set_tag_o    = tag;
        set_data_o   = fill_q;
        // only the last word marks the line valid, so a partial line never hits
        set_valid_o  = (w_q == 2'd3);
        if (set_ack_i) begin
          w_d = w_q + 2'd1;
          if (w_q == 2'd3) begin
            replay_d = 1'b1;
            ret_d    = CMP;
            state_d  = REL;
          end else begin
            state_d = FILL_MEM;
          end
        end else if (tmr_q == '0) begin
          state_d = ERR;
        end
      end
      DONE: begin
        cpu_ready_o = 1'b1;
        cpu_rdata_o = rdata_q;
        state_d     = IDLE;
      end
      ERR: begin
        cpu_ready_o = 1'b1;
        cpu_err_o   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // every command is a state change, so reloading on any transition restarts the wait budget
    if (state_d != state_q) tmr_d = TW'(TIMEOUT - 1);
    else if (tmr_q != '0)   tmr_d = tmr_q - TW'(1);
  end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [8:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_err, cpu_busy;
  logic [1:0]  set_sel, set_word;
  logic        set_enable, set_comp, set_write, set_valid;
  logic [4:0]  set_tag, set_tag_out;
  logic [15:0] set_data, set_data_out;
  logic        set_hit, set_dirty, set_valid_out, set_ack;
  logic        mem_req, mem_we, mem_ack;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_ctrl #(.IDX_W(2), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready), .cpu_err_o(cpu_err), .cpu_busy_o(cpu_busy),
    .set_sel_o(set_sel), .set_enable_o(set_enable), .set_comp_o(set_comp), .set_write_o(set_write),
    .set_word_o(set_word), .set_tag_o(set_tag), .set_data_o(set_data), .set_valid_o(set_valid),
    .set_hit_i(set_hit), .set_dirty_i(set_dirty), .set_valid_out_i(set_valid_out),
    .set_ack_i(set_ack), .set_tag_out_i(set_tag_out), .set_data_out_i(set_data_out),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  function automatic logic [8:0] mk(input logic [4:0] t, input logic [1:0] i, input logic [1:0] w);
    return {t, i, w};
  endfunction

  function automatic logic [15:0] pat(input logic [8:0] a);
    return {7'h61, a};
  endfunction

  // ---------------- set array and memory models ----------------
  logic        s_valid [4];
  logic        s_dirty [4];
  logic [4:0]  s_tag   [4];
  logic [15:0] s_data  [4][4];
  logic        clr_sets = 1'b0, clr_log = 1'b0, ack_kill = 1'b0;
  int          set_lat = 1, mem_lat = 1;
  int          scnt = 1, mcnt = 1;
  int          cmp_cnt = 0, fv_cnt = 0, op_cnt = 0;
  logic        fv     [16];
  logic        op_we  [16];
  logic [8:0]  op_addr[16];
  logic [15:0] op_data[16];

  always_comb begin
    set_hit       = s_valid[set_sel] && (s_tag[set_sel] == set_tag);
    set_dirty     = s_dirty[set_sel];
    set_valid_out = s_valid[set_sel];
    set_tag_out   = s_tag[set_sel];
    set_data_out  = s_data[set_sel][set_word];
    set_ack       = set_enable && (scnt == 0) && !ack_kill;
    mem_ack       = mem_req && (mcnt == 0);
    mem_rdata     = pat(mem_addr);
  end

  always @(posedge clk) begin
    if (set_enable && set_ack) begin
      if (set_comp) begin
        cmp_cnt <= cmp_cnt + 1;
        if (set_write && set_hit) begin
          s_data[set_sel][set_word] <= set_data;
          s_dirty[set_sel] <= 1'b1;
        end
      end else if (set_write) begin
        s_data[set_sel][set_word] <= set_data;
        s_tag[set_sel]   <= set_tag;
        s_valid[set_sel] <= set_valid;
        s_dirty[set_sel] <= 1'b0;
        fv[fv_cnt[3:0]]  <= set_valid;
        fv_cnt <= fv_cnt + 1;
      end
      scnt <= set_lat;
    end else if (set_enable) begin
      if (scnt != 0) scnt <= scnt - 1;
    end else begin
      scnt <= set_lat;
    end
    if (mem_req && mem_ack) begin
      op_we[op_cnt[3:0]]   <= mem_we;
      op_addr[op_cnt[3:0]] <= mem_addr;
      op_data[op_cnt[3:0]] <= mem_wdata;
      op_cnt <= op_cnt + 1;
      mcnt   <= mem_lat;
    end else if (mem_req) begin
      if (mcnt != 0) mcnt <= mcnt - 1;
    end else begin
      mcnt <= mem_lat;
    end
    if (clr_sets) begin
      for (int i = 0; i < 4; i++) begin
        s_valid[i] <= 1'b0;
        s_dirty[i] <= 1'b0;
        s_tag[i]   <= '0;
        for (int j = 0; j < 4; j++) s_data[i][j] <= '0;
      end
    end
    if (clr_log) begin
      cmp_cnt <= 0;
      fv_cnt  <= 0;
      op_cnt  <= 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_log();
    @(negedge clk); clr_log = 1'b1;
    @(negedge clk); clr_log = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && cpu_busy; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_req(input logic we, input logic [8:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output logic er, output int n);
    wait_idle();
    @(negedge clk);
    cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    n = -1; rd = '0; er = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      cpu_req = 1'b0;
      if (cpu_ready) begin
        rd = cpu_rdata; er = cpu_err; n = k;
        break;
      end
    end
    if (n < 0) begin
      checks++; errors++;
      $display("FAIL req_timeout: no cpu_ready for addr %0h within 400 cycles", a);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    clr_sets = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cpu_rdata, cpu_ready, cpu_err, cpu_busy, set_sel, set_enable, set_comp, set_write,
         set_word, set_tag, set_data, set_valid, mem_req, mem_we, mem_addr, mem_wdata} !== 75'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b en=%b mem_req=%b, expected all outputs 0",
               cpu_busy, set_enable, mem_req);
    end
    @(negedge clk); rst_n = 1'b1; clr_sets = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cpu_busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b expected 0", cpu_busy);
    end
  endtask

  task automatic test_fill_then_hit();
    logic [15:0] rd; logic er; int n;
    clear_log();
    do_req(1'b1, mk(3, 1, 2), 16'h1234, rd, er, n);
    checks++;
    if (op_cnt !== 4 || er !== 1'b0) begin
      errors++; $display("FAIL wmiss_fill: got ops=%0d err=%b expected ops=4 err=0", op_cnt, er);
    end
    clear_log();
    do_req(1'b0, mk(3, 1, 2), 16'h0, rd, er, n);
    checks++;
    if (rd !== 16'h1234) begin
      errors++; $display("FAIL hit_rdata: got %h expected 1234", rd);
    end
    checks++;
    if (cmp_cnt !== 1 || op_cnt !== 0) begin
      errors++; $display("FAIL hit_one_cmp: got cmp=%0d ops=%0d expected cmp=1 ops=0", cmp_cnt, op_cnt);
    end
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL hit_latency: got %0d cycles expected 3", n);
    end
  endtask

  task automatic test_clean_miss();
    logic [15:0] rd; logic er; int n; int bad;
    clear_log();
    do_req(1'b0, mk(5, 2, 1), 16'h0, rd, er, n);
    checks++;
    if (op_cnt !== 4) begin
      errors++; $display("FAIL clean_ops: got %0d expected 4", op_cnt);
    end
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (op_we[i] !== 1'b0 || op_addr[i] !== mk(5, 2, 2'(i))) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL clean_fill_addr: got %0d wrong ops expected 0", bad);
    end
    checks++;
    if (fv_cnt !== 4 || {fv[0], fv[1], fv[2], fv[3]} !== 4'b0001) begin
      errors++; $display("FAIL fill_valid_in: got cnt=%0d bits=%b%b%b%b expected 4 and 0001",
                         fv_cnt, fv[0], fv[1], fv[2], fv[3]);
    end
    checks++;
    if (cmp_cnt !== 2 || er !== 1'b0) begin
      errors++; $display("FAIL clean_replay: got cmp=%0d err=%b expected cmp=2 err=0", cmp_cnt, er);
    end
    checks++;
    if (rd !== pat(mk(5, 2, 1))) begin
      errors++; $display("FAIL clean_rdata: got %h expected %h", rd, pat(mk(5, 2, 1)));
    end
  endtask

  task automatic test_dirty_miss();
    logic [15:0] rd; logic er; int n; int bad;
    logic [15:0] exp_wb [4];
    exp_wb[0] = 16'hBEEF; exp_wb[1] = pat(mk(3, 1, 1));
    exp_wb[2] = 16'h1234; exp_wb[3] = pat(mk(3, 1, 3));
    clear_log();
    do_req(1'b1, mk(3, 1, 0), 16'hBEEF, rd, er, n);
    checks++;
    if (cmp_cnt !== 1 || op_cnt !== 0) begin
      errors++; $display("FAIL write_hit: got cmp=%0d ops=%0d expected 1 and 0", cmp_cnt, op_cnt);
    end
    clear_log();
    do_req(1'b0, mk(7, 1, 3), 16'h0, rd, er, n);
    checks++;
    if (op_cnt !== 8) begin
      errors++; $display("FAIL dirty_ops: got %0d expected 8", op_cnt);
    end
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (op_we[i] !== 1'b1 || op_addr[i] !== mk(3, 1, 2'(i)) || op_data[i] !== exp_wb[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL writeback: got %0d wrong writes expected 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (op_we[i+4] !== 1'b0 || op_addr[i+4] !== mk(7, 1, 2'(i))) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL dirty_fill: got %0d wrong reads expected 0", bad);
    end
    checks++;
    if (rd !== pat(mk(7, 1, 3)) || er !== 1'b0) begin
      errors++; $display("FAIL dirty_rdata: got %h err=%b expected %h err=0", rd, er, pat(mk(7, 1, 3)));
    end
  endtask

  task automatic test_timeout();
    logic [15:0] rd; logic er; int n;
    ack_kill = 1'b1;
    do_req(1'b0, mk(1, 0, 0), 16'h0, rd, er, n);
    checks++;
    if (n !== 65) begin
      errors++; $display("FAIL timeout_cycles: got %0d expected 65", n);
    end
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL timeout_err: got %b expected 1", er);
    end
    checks++;
    if (set_enable !== 1'b0) begin
      errors++; $display("FAIL timeout_enable: got %b expected 0", set_enable);
    end
    ack_kill = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] rd; logic er; int n; logic seen;
    do_req(1'b1, mk(7, 1, 0), 16'h5A5A, rd, er, n);
    wait_idle();
    mem_lat = 5;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = mk(2, 1, 0); cpu_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      cpu_req = 1'b0;
      if (mem_req && mem_we) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL reach_wb_mem: got no memory write expected one");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_rdata, cpu_ready, cpu_err, cpu_busy, set_sel, set_enable, set_comp, set_write,
         set_word, set_tag, set_data, set_valid, mem_req, mem_we, mem_addr, mem_wdata} !== 75'd0) begin
      errors++; $display("FAIL midop_reset: got busy=%b mem_req=%b mem_we=%b expected all 0",
                         cpu_busy, mem_req, mem_we);
    end
    @(negedge clk); rst_n = 1'b1; mem_lat = 1;
    clear_log();
    do_req(1'b0, mk(7, 1, 0), 16'h0, rd, er, n);
    checks++;
    if (rd !== 16'h5A5A || n !== 3 || er !== 1'b0) begin
      errors++; $display("FAIL post_reset_hit: got rd=%h n=%0d err=%b expected 5a5a 3 0", rd, n, er);
    end
    checks++;
    if (op_cnt !== 0) begin
      errors++; $display("FAIL post_reset_ops: got %0d expected 0", op_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int accepts, readies; logic prev_busy;
    wait_idle();
    clear_log();
    accepts = 0; readies = 0; prev_busy = cpu_busy;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = mk(7, 1, 0); cpu_req = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (cpu_busy && !prev_busy) accepts++;
      prev_busy = cpu_busy;
      if (cpu_ready) begin
        readies++;
        if (readies == 2) begin
          cpu_req = 1'b0;
          break;
        end
      end
    end
    cpu_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (cpu_busy && !prev_busy) accepts++;
      prev_busy = cpu_busy;
    end
    checks++;
    if (readies !== 2 || accepts !== 2) begin
      errors++; $display("FAIL held_req: got accepts=%0d readies=%0d expected 2 and 2", accepts, readies);
    end
    checks++;
    if (cmp_cnt !== 2) begin
      errors++; $display("FAIL held_req_cmp: got %0d expected 2", cmp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fill_then_hit();
    test_clean_miss();
    test_dirty_miss();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
